// File: rtl/and_or_feeder.sv
`default_nettype none
// ============================================================================
// Module   : and_or_feeder
// Brief    : Command FIFO that issues AND/OR operations to an external
//            and_or stage and captures the returned results.
// Revision : 1.0 - initial release
// ============================================================================
module and_or_feeder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [WIDTH-1:0]         aIn,
    input  logic [WIDTH-1:0]         bIn,
    input  logic [1:0]               opSel,
    output logic [WIDTH-1:0]         aOut,
    output logic [WIDTH-1:0]         bOut,
    output logic                     doAnd,
    output logic                     doOr,
    input  logic                     isAnd,
    input  logic [WIDTH-1:0]         resIn,
    output logic [WIDTH-1:0]         resOut,
    output logic                     resIsAnd,
    output logic                     resValid,
    output logic                     errIllegal,
    output logic                     errMismatch,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int         AW     = $clog2(DEPTH);
    localparam int         LW     = AW + 1;
    localparam int         EW     = 2 * WIDTH + 2;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    state_t           state_q;

    logic [WIDTH-1:0] aOut_q;
    logic [WIDTH-1:0] bOut_q;
    logic             doAnd_q;
    logic             doOr_q;
    logic [WIDTH-1:0] resOut_q;
    logic             resIsAnd_q;
    logic             resValid_q;
    logic             errIllegal_q;
    logic             errMismatch_q;

    logic             w_full;
    logic             w_op_legal;
    logic             w_push;
    logic             w_pop;
    logic             w_illegal;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic [1:0]       w_head_op;

    assign w_full     = (level_q == LW'(DEPTH));
    assign w_op_legal = (opSel == OP_AND) || (opSel == OP_OR);
    assign w_push     = inValid && !w_full && w_op_legal;
    assign w_illegal  = inValid && !w_op_legal;
    // The engine accepts a new command when idle or while retiring the previous one.
    assign w_pop      = ((state_q == IDLE) || (state_q == CAPTURE)) && (level_q != '0);

    assign {w_head_a, w_head_b, w_head_op} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is not reset; occupancy is governed entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {aIn, bIn, opSel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            aOut_q        <= '0;
            bOut_q        <= '0;
            doAnd_q       <= 1'b0;
            doOr_q        <= 1'b0;
            resOut_q      <= '0;
            resIsAnd_q    <= 1'b0;
            resValid_q    <= 1'b0;
            errIllegal_q  <= 1'b0;
            errMismatch_q <= 1'b0;
        end else begin
            resValid_q <= 1'b0;
            if (w_illegal) begin
                errIllegal_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (w_pop) begin
                        aOut_q  <= w_head_a;
                        bOut_q  <= w_head_b;
                        doAnd_q <= (w_head_op == OP_AND);
                        doOr_q  <= (w_head_op == OP_OR);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    resOut_q   <= resIn;
                    resIsAnd_q <= isAnd;
                    resValid_q <= 1'b1;
                    if (isAnd != doAnd_q) begin
                        errMismatch_q <= 1'b1;
                    end
                    if (w_pop) begin
                        aOut_q  <= w_head_a;
                        bOut_q  <= w_head_b;
                        doAnd_q <= (w_head_op == OP_AND);
                        doOr_q  <= (w_head_op == OP_OR);
                        state_q <= ISSUE;
                    end else begin
                        doAnd_q <= 1'b0;
                        doOr_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inReady     = !w_full;
    assign level       = level_q;
    assign aOut        = aOut_q;
    assign bOut        = bOut_q;
    assign doAnd       = doAnd_q;
    assign doOr        = doOr_q;
    assign resOut      = resOut_q;
    assign resIsAnd    = resIsAnd_q;
    assign resValid    = resValid_q;
    assign errIllegal  = errIllegal_q;
    assign errMismatch = errMismatch_q;

endmodule
`default_nettype wire
